// File: rtl/dht11_pkg.sv
`timescale 1ns/1ps
// Shared DHT11 protocol constants: state encodings, phase durations (us) and
// bus direction codes used by both the host reader and the sensor emulator.
package dht11_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START_L  = 3'd1;
    localparam logic [2:0] ST_WAIT_REL = 3'd2;
    localparam logic [2:0] ST_RESP_L   = 3'd3;
    localparam logic [2:0] ST_RESP_H   = 3'd4;
    localparam logic [2:0] ST_BIT_L    = 3'd5;
    localparam logic [2:0] ST_BIT_H    = 3'd6;
    localparam logic [2:0] ST_END_L    = 3'd7;

    localparam int unsigned T_HOST_START_US = 18;
    localparam int unsigned T_RESP_DELAY_US = 20;
    localparam int unsigned T_BIT0_HIGH_US  = 26;
    localparam int unsigned T_BIT_LOW_US    = 50;
    localparam int unsigned T_BIT1_HIGH_US  = 70;
    localparam int unsigned T_RESP_US       = 80;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    function automatic logic [7:0] dht11_cksum(input logic [15:0] hum, input logic [15:0] temp);
        return hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
    endfunction

endpackage

// File: rtl/dht11_sensor_emu_if.sv
`timescale 1ns/1ps
// Data/status bundle of the DHT11 sensor emulator; the inject_cksum_err
// input exists only when DHT11_EMU_CKSUM_ERR_EN is defined.
interface dht11_sensor_emu_if;

    logic [15:0] umidade;
    logic [15:0] temperatura;
    logic        busy;
    logic        frame_done;
    logic        short_start;
`ifdef DHT11_EMU_CKSUM_ERR_EN
    logic        inject_cksum_err;
`endif

    modport master (
`ifdef DHT11_EMU_CKSUM_ERR_EN
        output inject_cksum_err,
`endif
        output umidade, temperatura,
        input  busy, frame_done, short_start
    );

    modport slave (
`ifdef DHT11_EMU_CKSUM_ERR_EN
        input  inject_cksum_err,
`endif
        input  umidade, temperatura,
        output busy, frame_done, short_start
    );

endinterface

// File: rtl/dht11_bit_timer.sv
`timescale 1ns/1ps
// Loadable down-counter timing every protocol phase; expired is high while
// the count sits at zero, so a load of N-1 spans exactly N cycles.
module dht11_bit_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = len;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/dht11_sensor_emu.sv
`timescale 1ns/1ps
// DHT11 sensor emulator: answers a host start pulse with the handshake and a
// 40-bit frame, open-drain. Optional DHT11_EMU_CKSUM_ERR_EN corrupts the checksum.
module dht11_sensor_emu
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_PER_US    = 50,
    parameter int unsigned MIN_START_US  = 15,
    parameter int unsigned RESP_DELAY_US = 20
) (
    input  logic                clock,
    input  logic                reset,
    inout  wire                 dht_bus,
    dht11_sensor_emu_if.slave   emu
);

    localparam int unsigned CW = $clog2(T_RESP_US * CLK_PER_US);

    localparam logic [CW-1:0] MIN_START_CNT = CW'(MIN_START_US * CLK_PER_US);
    localparam logic [CW-1:0] LEN_WAIT      = CW'(RESP_DELAY_US * CLK_PER_US - 4);
    localparam logic [CW-1:0] LEN_RESP      = CW'(T_RESP_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LEN_BIT_LOW   = CW'(T_BIT_LOW_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LEN_BIT0      = CW'(T_BIT0_HIGH_US * CLK_PER_US - 1);
    localparam logic [CW-1:0] LEN_BIT1      = CW'(T_BIT1_HIGH_US * CLK_PER_US - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [39:0]   frame_q, frame_d;
    logic [5:0]    idx_q, idx_d;
    logic          drive_low_q, drive_low_d;
    logic          frame_done_q, frame_done_d;
    logic          short_start_q, short_start_d;
    logic          tmr_load;
    logic [CW-1:0] tmr_len;
    logic          tmr_expired;
    logic [7:0]    cksum;
    logic          bus_s;

    assign bus_s = sync2_q;

`ifdef DHT11_EMU_CKSUM_ERR_EN
    assign cksum = dht11_cksum(emu.umidade, emu.temperatura) ^ {7'b0, emu.inject_cksum_err};
`else
    assign cksum = dht11_cksum(emu.umidade, emu.temperatura);
`endif

    dht11_bit_timer #(.W(CW)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (tmr_load),
        .len     (tmr_len),
        .expired (tmr_expired)
    );

    always_comb begin
        // Our own low is masked out of the synchronizer, so the end-of-frame
        // low still in flight cannot re-trigger a start once back in IDLE.
        sync1_d       = drive_low_q ? 1'b1 : dht_bus;
        sync2_d       = sync1_q;
        state_d       = state_q;
        count_d       = count_q;
        frame_d       = frame_q;
        idx_d         = idx_q;
        frame_done_d  = 1'b0;
        short_start_d = 1'b0;
        tmr_load      = 1'b0;
        tmr_len       = '0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (!bus_s) begin
                    state_d = ST_START_L;
                end
            end
            ST_START_L: begin
                if (!bus_s) begin
                    if (count_q != '1) begin
                        count_d = count_q + CW'(1);
                    end
                end else if (count_q >= MIN_START_CNT) begin
                    frame_d  = {emu.umidade, emu.temperatura, cksum};
                    count_d  = '0;
                    state_d  = ST_WAIT_REL;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_WAIT;
                end else begin
                    short_start_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_WAIT_REL: begin
                if (tmr_expired) begin
                    state_d  = ST_RESP_L;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_RESP;
                end
            end
            ST_RESP_L: begin
                if (tmr_expired) begin
                    state_d  = ST_RESP_H;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_RESP;
                end
            end
            ST_RESP_H: begin
                if (tmr_expired) begin
                    state_d  = ST_BIT_L;
                    idx_d    = 6'd39;
                    tmr_load = 1'b1;
                    tmr_len  = LEN_BIT_LOW;
                end
            end
            ST_BIT_L: begin
                if (tmr_expired) begin
                    state_d  = ST_BIT_H;
                    tmr_load = 1'b1;
                    tmr_len  = frame_q[idx_q] ? LEN_BIT1 : LEN_BIT0;
                end
            end
            ST_BIT_H: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_len  = LEN_BIT_LOW;
                    if (idx_q == '0) begin
                        state_d = ST_END_L;
                    end else begin
                        idx_d   = idx_q - 6'd1;
                        state_d = ST_BIT_L;
                    end
                end
            end
            ST_END_L: begin
                if (tmr_expired) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        drive_low_d = (state_d == ST_RESP_L) || (state_d == ST_BIT_L) || (state_d == ST_END_L);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= ST_IDLE;
            count_q       <= '0;
            frame_q       <= '0;
            idx_q         <= '0;
            drive_low_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            short_start_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            state_q       <= state_d;
            count_q       <= count_d;
            frame_q       <= frame_d;
            idx_q         <= idx_d;
            drive_low_q   <= drive_low_d;
            frame_done_q  <= frame_done_d;
            short_start_q <= short_start_d;
        end
    end

    assign dht_bus         = drive_low_q ? 1'b0 : 1'bz;
    assign emu.busy        = (state_q != ST_IDLE) && (state_q != ST_START_L);
    assign emu.frame_done  = frame_done_q;
    assign emu.short_start = short_start_q;

endmodule

// File: doc/dht11_sensor_emu.md
# dht11_sensor_emu

Single-wire DHT11 sensor emulator: the responder end of the DHT11 protocol whose initiator is the `dht11` host reader. It watches the shared `dht_bus` for a host start pulse and then answers with the sensor handshake and a 40-bit humidity/temperature frame. It drives the bus open-drain and releases it otherwise. It sits in the board/bench top next to the host reader, allowing closed-loop test without a physical sensor.

## Interface
- `CLK_PER_US`, 50: clock cycles per microsecond (50 MHz).
- `MIN_START_US`, 15: minimum host low pulse accepted as a start.
- `RESP_DELAY_US`, 20: delay from host rising edge to responder's first low.
- `clock` input 1: single clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `dht_bus` inout 1: open-drain, drives `0` or `z` only, never `1`; pull-up is external.
- `umidade` input 16: humidity, integer byte in [15:8], decimal byte in [7:0].
- `temperatura` input 16: temperature, same split.
- `busy` output 1: high from accepted start until frame end.
- `frame_done` output 1: one-cycle pulse after the end-of-frame low is released.
- `short_start` output 1: one-cycle pulse when a host low shorter than `MIN_START_US` is discarded.

## Operation
- `dht_bus` is sampled through a 2-FF synchronizer, giving `bus_s`.
- The drive enable is a register, `drive_low`. `dht_bus = drive_low ? 0 : z`.
- States:
  - IDLE: `bus_s==0` → START_L; counter cleared.
  - START_L: count while `bus_s==0`, saturating. On `bus_s==1`:
    - if count ≥ `MIN_START_US*CLK_PER_US` → latch the frame, counter cleared, go to WAIT_REL;
    - else pulse `short_start` and go to IDLE.
  - WAIT_REL: count `RESP_DELAY_US*CLK_PER_US − 3` cycles (compensates synchronizer plus register latency), then go to RESP_L. The host drives high during this window and the responder stays `z`.
  - RESP_L: drive low 80 µs, then go to RESP_H.
  - RESP_H: release 80 µs, then go to BIT_L with bit index 39.
  - BIT_L: drive low 50 µs, then go to BIT_H.
  - BIT_H: release 26 µs for bit 0 or 70 µs for bit 1. If index==0 go to END_L, else decrement index and go to BIT_L.
  - END_L: drive low 50 µs, release, pulse `frame_done`, go to IDLE.
- Frame latched at start acceptance, sent MSB first: {umidade[15:8], umidade[7:0], temperatura[15:8], temperatura[7:0], cksum}.
  - `cksum` = 8-bit sum of the four bytes, mod 256, carry discarded.
  - Input changes after latching do not affect the frame in progress.
- The bus is not monitored from RESP_L through END_L; host activity there is ignored.
- `busy` = state ∉ {IDLE, START_L}.

## Timing
- Reset values: `drive_low=0` (bus `z`), `busy=0`, `frame_done=0`, `short_start=0`, state IDLE, counters 0, frame 0.
- Reset mid-frame releases the bus on the same clock edge and returns to IDLE; no `frame_done` is issued.
- Phase durations are exact cycle counts (`N*CLK_PER_US`): 80 µs = 4000, 50 µs = 2500, 26 µs = 1300, 70 µs = 3500 at default.
- First responder low appears `RESP_DELAY_US*CLK_PER_US` ±1 cycles after the host rising edge on the pin.
- Frame length at default: 20 + 80 + 80 + 40·50 + Σhigh + 50 µs.
- Counter width: `$clog2(80*CLK_PER_US)` bits; the START_L counter saturates and does not wrap.

## Configuration
- `DHT11_EMU_CKSUM_ERR_EN`:
  - defined: adds input `inject_cksum_err` (1 bit), sampled at start acceptance; when set, the transmitted checksum is `cksum ^ 8'h01`.
  - undefined: the port is absent and the checksum is always correct.

## Structure
- Package `dht11_pkg` holds:
  - state encoding localparams;
  - protocol durations in µs: 18, 20, 26, 50, 70, 80;
  - `READ`/`WRITE` direction constants shared with the host reader.
- Sub-module `dht11_bit_timer` is natural: a loadable down-counter with `load`, `len`, `expired` outputs, reused by every timed state.

## Test plan
- Reset held 5 cycles → `dht_bus` is `z`, `busy=0`, no pulses; after release it stays in IDLE with the bus high.
- Host low 18 µs, high 20 µs, `umidade=16'h3700`, `temperatura=16'h1A00`:
  - response low at 1000±1 cycles after the rise, then 4000 low / 4000 high;
  - bytes 0x37, 0x00, 0x1A, 0x00, 0x51;
  - `frame_done` pulses once.
- Host low 10 µs → `short_start` pulses once, bus stays `z`, `busy=0`.
- Data 0xFF, 0x00, 0x00, 0x00 → high widths 3500 cycles for the first 8 bits and 1300 cycles for the next 24; checksum 0xFF.
- Bytes 0xC8, 0x64, 0x50, 0x32 → checksum 0xAE. With `DHT11_EMU_CKSUM_ERR_EN` and `inject_cksum_err=1` → 0xAF.
- Closed loop with the `dht11` host, reset asserted during bit 20 → bus `z` on the next edge, state IDLE; a following start completes with a correct frame.
